// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the state encoding, opcode constants and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Pure combinational Moore-style output decode for the multicycle controller.
// Only FETCH looks at mem_ready; only DECODE and BRANCH look at the opcode.
module mc_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = ~op_is_legal(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (opcode == OP_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, opcode latch and next-state logic.
// Output decode lives in mc_out_decode.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        BranchNe,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        ALUsrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUsrcB,
    output logic [2:0]  ALUop,
    output logic        illegal_op,
    output logic [3:0]  state_o
);

    state_t      state_reg;
    state_t      state_next;
    logic [5:0]  opcode_reg;
    logic [5:0]  op_eff;
    ctrl_t       ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            opcode_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                opcode_reg <= opcode;
        end
    end

    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    state_next = S_MEMADR;
                    OP_RTYPE:        state_next = S_EXEC;
                    OP_ADDI:         state_next = S_ADDIEX;
                    OP_BEQ, OP_BNE:  state_next = S_BRANCH;
                    OP_J:            state_next = S_JUMP;
                    default:         state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (opcode_reg == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // The latch only captures at the end of DECODE, so DECODE itself must see the live field.
    assign op_eff = (state_reg == S_DECODE) ? opcode : opcode_reg;

    mc_out_decode u_out_decode (
        .state     (state_reg),
        .opcode    (op_eff),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign BranchNe    = ctrl.branch_ne;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign ALUsrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign PCSource    = ctrl.pc_source;
    assign ALUsrcB     = ctrl.alu_src_b;
    assign ALUop       = ctrl.alu_op;
    assign illegal_op  = ctrl.illegal_op;
    assign state_o     = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-cycle trace comparison against an
// instruction-level reference model, plus latency and reset scenarios.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
    logic        MemtoReg, IRWrite, ALUsrcA, RegWrite, RegDst, illegal_op;
    logic [1:0]  PCSource, ALUsrcB;
    logic [2:0]  ALUop;
    logic [3:0]  state_o;

    int checks = 0;
    int errors = 0;
    int st_q[$];
    bit rdy_q[$];

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ADDI = 6'b001000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
        .ALUsrcA(ALUsrcA), .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource),
        .ALUsrcB(ALUsrcB), .ALUop(ALUop), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] op);
        return op inside {LW, SW, RT, ADDI, BEQ, BNE, JMP};
    endfunction

    function automatic logic [18:0] dut_out();
        return {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                ALUsrcA, RegWrite, RegDst, PCSource, ALUsrcB, ALUop, illegal_op};
    endfunction

    // Expected control word for one cycle, straight from the per-state output list.
    function automatic logic [18:0] exp_out(input int st, input logic [5:0] op, input bit rdy);
        logic pcw, pcwc, bne, iord, mr, mw, m2r, irw, asa, rw, rd, ill;
        logic [1:0] pcs, asb;
        logic [2:0] aop;
        {pcw, pcwc, bne, iord, mr, mw, m2r, irw, asa, rw, rd, ill} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 3'b000;
        case (st)
            1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            2:  begin asb = 2'b11; ill = !legal(op); end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; iord = 1; end
            7:  begin asa = 1; aop = 3'b010; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; bne = (op == BNE); end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin asa = 1; asb = 2'b10; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, bne, iord, mr, mw, m2r, irw, asa, rw, rd, pcs, asb, aop, ill};
    endfunction

    task automatic add_wait(input int st, input int stalls);
        for (int i = 0; i < stalls; i++) begin st_q.push_back(st); rdy_q.push_back(1'b0); end
        st_q.push_back(st); rdy_q.push_back(1'b1);
    endtask

    task automatic add_any(input int st);
        st_q.push_back(st); rdy_q.push_back(bit'($urandom_range(0, 1)));
    endtask

    // Instruction-level model: the expected state walk for one instruction.
    task automatic build(input logic [5:0] op, input int f_stall, input int m_stall);
        st_q.delete(); rdy_q.delete();
        add_wait(1, f_stall);
        add_any(2);
        case (op)
            LW:       begin add_any(3); add_wait(4, m_stall); add_any(5); end
            SW:       begin add_any(3); add_wait(6, m_stall); end
            RT:       begin add_any(7); add_any(8); end
            ADDI:     begin add_any(11); add_any(12); end
            BEQ, BNE: add_any(9);
            JMP:      add_any(10);
            default:  ;
        endcase
    endtask

    // Plays the built trace; opcode is only meaningful in DECODE and is scrambled elsewhere.
    task automatic run_trace(input logic [5:0] op, input int limit, input bit end_check,
                             output int mw_cycles, output int rw_cycles);
        int n;
        mw_cycles = 0; rw_cycles = 0;
        n = (limit < st_q.size()) ? limit : st_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = rdy_q[i];
            opcode = (st_q[i] == 2) ? op : 6'($urandom);
            #1;
            checks++;
            if (state_o !== 4'(st_q[i])) begin
                errors++;
                $display("FAIL state op=%b step=%0d actual=%0d required=%0d", op, i, state_o, st_q[i]);
            end
            checks++;
            if (dut_out() !== exp_out(st_q[i], op, rdy_q[i])) begin
                errors++;
                $display("FAIL outputs op=%b step=%0d state=%0d actual=%b required=%b",
                         op, i, st_q[i], dut_out(), exp_out(st_q[i], op, rdy_q[i]));
            end
            checks++;
            if (MemRead && MemWrite) begin
                errors++;
                $display("FAIL rd_wr_exclusive op=%b step=%0d actual=11 required=not both", op, i);
            end
            if (MemWrite) mw_cycles++;
            if (RegWrite) rw_cycles++;
        end
        if (end_check) begin
            @(posedge clk); #1;
            checks++;
            if (state_o !== 4'd1) begin
                errors++;
                $display("FAIL return_to_fetch op=%b actual=%0d required=1", op, state_o);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (state_o !== 4'd0 || dut_out() !== 19'd0) begin
                errors++;
                $display("FAIL reset_hold actual state=%0d outs=%b required state=0 outs=0", state_o, dut_out());
            end
            @(posedge clk); #1;
        end
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
        checks++;
        if (state_o !== 4'd0 || dut_out() !== 19'd0) begin
            errors++;
            $display("FAIL reset_idle actual state=%0d outs=%b required state=0 outs=0", state_o, dut_out());
        end
        @(posedge clk); #1;
        checks++;
        if (state_o !== 4'd1) begin
            errors++;
            $display("FAIL reset_to_fetch actual=%0d required=1", state_o);
        end
        $display("reset: idle then fetch");
    endtask

    task automatic test_random_instrs(input int count);
        logic [5:0] ops[7] = '{LW, SW, RT, ADDI, BEQ, BNE, JMP};
        logic [5:0] op;
        int fs, ms, mw, rw;
        for (int k = 0; k < count; k++) begin
            int sel = $urandom_range(0, 7);
            if (sel == 7) begin
                op = 6'($urandom);
                if (legal(op)) op = 6'b111111;
            end else begin
                op = ops[sel];
            end
            fs = $urandom_range(0, 2);
            ms = $urandom_range(0, 3);
            build(op, fs, ms);
            run_trace(op, 1000, 1'b1, mw, rw);
            $display("instr op=%b fetch_stall=%0d mem_stall=%0d cycles=%0d", op, fs, ms, st_q.size());
        end
    endtask

    task automatic test_sw_stall();
        int mw, rw;
        build(SW, 0, 3);
        run_trace(SW, 1000, 1'b1, mw, rw);
        checks++;
        if (mw != 4 || rw != 0) begin
            errors++;
            $display("FAIL sw_stall actual memwrite=%0d regwrite=%0d required memwrite=4 regwrite=0", mw, rw);
        end
        $display("sw stall: memwrite cycles=%0d regwrite cycles=%0d", mw, rw);
    endtask

    task automatic test_illegal();
        int mw, rw, ill_cycles;
        build(6'b111111, 0, 0);
        ill_cycles = 0;
        run_trace(6'b111111, 1000, 1'b1, mw, rw);
        if (illegal_op) ill_cycles++;
        checks++;
        if (ill_cycles != 0 || mw != 0 || rw != 0) begin
            errors++;
            $display("FAIL illegal_pulse actual ill_after=%0d mw=%0d rw=%0d required 0 0 0", ill_cycles, mw, rw);
        end
        $display("illegal op=111111 back in fetch");
    endtask

    task automatic test_latency();
        logic [5:0] ops[6] = '{LW, SW, RT, ADDI, BEQ, JMP};
        int lat_exp[6] = '{5, 4, 4, 4, 3, 3};
        int n;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            opcode = ops[k];
            n = 1;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (state_o == 4'd1) break;
                n++;
            end
            checks++;
            if (n != lat_exp[k]) begin
                errors++;
                $display("FAIL latency op=%b actual=%0d required=%0d", ops[k], n, lat_exp[k]);
            end
            $display("latency op=%b cycles=%0d", ops[k], n);
        end
    endtask

    task automatic test_async_reset();
        int mw, rw;
        build(LW, 0, 5);
        run_trace(LW, 4, 1'b0, mw, rw);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || dut_out() !== 19'd0) begin
            errors++;
            $display("FAIL async_reset actual state=%0d outs=%b required state=0 outs=0", state_o, dut_out());
        end
        @(posedge clk); #1;
        checks++;
        if (state_o !== 4'd0 || dut_out() !== 19'd0) begin
            errors++;
            $display("FAIL reset_held actual state=%0d outs=%b required state=0 outs=0", state_o, dut_out());
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL release_idle actual=%0d required=0", state_o);
        end
        @(posedge clk); #1;
        checks++;
        if (state_o !== 4'd1) begin
            errors++;
            $display("FAIL release_fetch actual=%0d required=1", state_o);
        end
        $display("async reset during memrd: aborted, restarted idle then fetch");
    endtask

    initial begin
        test_reset();
        test_random_instrs(40);
        test_sw_stall();
        test_illegal();
        test_async_reset();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port opcode, input, 6 bits: instruction-register opcode field, sampled only in DECODE.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory completes the current read or write this cycle.
REQ-005 SHALL have outputs PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUsrcA, RegWrite, RegDst, 1 bit each: datapath enables and mux selects.
REQ-006 SHALL have output PCSource, 2 bits: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-007 SHALL have output ALUsrcB, 2 bits: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2.
REQ-008 SHALL have output ALUop, 3 bits: 000 add, 001 subtract, 010 funct-decoded.
REQ-009 SHALL have output illegal_op, 1 bit: one-cycle pulse on an undecodable opcode.
REQ-010 SHALL have output state_o, 4 bits: current state encoding, for debug.

Function
REQ-011 SHALL implement states IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12; codes 13-15 SHALL go to IDLE.
REQ-012 SHALL move IDLE->FETCH unconditionally.
REQ-013 In FETCH: MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=000; stay in FETCH while mem_ready=0; when mem_ready=1, pulse IRWrite=1 and PCWrite=1 (PCSource=00) and go to DECODE.
REQ-014 In DECODE: ALUsrcA=0, ALUsrcB=11, ALUop=000 (branch target into ALUOut); next state by opcode: 100011/101011->MEMADR, 000000->EXEC, 001000->ADDIEX, 000100/000101->BRANCH, 000010->JUMP, any other opcode->FETCH with illegal_op=1 for that cycle.
REQ-015 MEMADR: ALUsrcA=1, ALUsrcB=10, ALUop=000; goes to MEMRD if the latched opcode is lw, otherwise MEMWR.
REQ-016 MEMRD: MemRead=1, IorD=1; holds while mem_ready=0; goes to MEMWB on mem_ready=1.
REQ-017 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; goes to FETCH.
REQ-018 MEMWR: MemWrite=1, IorD=1; holds while mem_ready=0; goes to FETCH on mem_ready=1.
REQ-019 EXEC: ALUsrcA=1, ALUsrcB=00, ALUop=010; goes to ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; goes to FETCH.
REQ-020 ADDIEX: ALUsrcA=1, ALUsrcB=10, ALUop=000; goes to ADDIWB. ADDIWB: RegWrite=1, RegDst=0; goes to FETCH.
REQ-021 BRANCH: ALUsrcA=1, ALUsrcB=00, ALUop=001, PCWriteCond=1, PCSource=01, BranchNe=1 only for opcode 000101; goes to FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; goes to FETCH.
REQ-023 The opcode SHALL be latched in DECODE; later states SHALL use the latched copy and ignore changes on opcode.
REQ-024 Every output not listed for a state SHALL be 0; MemRead and MemWrite SHALL never be 1 together.
REQ-025 Latency with mem_ready tied to 1, counted from FETCH entry to the next FETCH entry: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles; each mem_ready=0 cycle adds one cycle.

Reset
REQ-026 While rst_n=0: state=IDLE, latched opcode=0, all outputs 0, state_o=0.
REQ-027 Reset asserted mid-instruction SHALL abort the instruction immediately (asynchronously), with no further write enable asserted; after release the block SHALL restart at IDLE.

Structure
REQ-028 A shared package mips_ctrl_pkg SHALL hold the state encoding, the opcode constants and the ALUop/PCSource/ALUsrcB codes.
REQ-029 Output decode SHALL be one combinational sub-module, mc_out_decode (inputs: state, latched opcode, mem_ready); the state register and next-state logic SHALL stay in multicycle_control.

Verification
REQ-030 lw (100011), mem_ready=1 -> states 1,2,3,4,5,1; MemtoReg=1 and RegWrite=1 only in state 5.
REQ-031 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held high for 4 cycles, RegWrite=0 throughout, then FETCH.
REQ-032 bne (000101) -> BRANCH with ALUop=001, PCWriteCond=1, BranchNe=1; beq gives BranchNe=0.
REQ-033 Opcode 111111 in DECODE -> illegal_op=1 for exactly 1 cycle, next state FETCH, no write enables asserted.
REQ-034 rst_n pulled low during MEMRD -> all outputs 0 immediately; after release, sequence IDLE then FETCH.
REQ-035 opcode changed during EXEC -> R-type sequence completes unchanged through ALUWB.
